dcache_lsu: RTL and testbench

Load/store unit sitting directly upstream of the 16-bit, 256-word data cache. It accepts one memory request at a time from the pipeline's execute stage over a valid/ready handshake, translates byte addresses to word indices, and drives the cache's synchronous read/write port. It performs byte stores as read-modify-write, and returns formatted load data or a store acknowledgement over a second valid/ready handshake.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_byte_lane.sv | 20 ++
 rtl/dcache_lsu.sv | 148 ++++++++++++++
 tb/tb_dcache_lsu.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-cache load/store unit.
// Latency constants count cycles from the accept edge to resp_valid high.
package lsu_pkg;

   localparam int LSU_ADDR_WORDS = 256;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LD_RD   = 3'd1,
      S_LD_CAP  = 3'd2,
      S_ST_WR   = 3'd3,
      S_RMW_RD  = 3'd4,
      S_RMW_MRG = 3'd5,
      S_RESP    = 3'd6
   } state_t;

   localparam logic LANE_LO = 1'b0;
   localparam logic LANE_HI = 1'b1;

   localparam int LAT_LOAD   = 3;
   localparam int LAT_WSTORE = 2;
   localparam int LAT_BSTORE = 4;
   localparam int LAT_ERR    = 1;

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane helper: lane extract with zero/sign fill for loads,
// lane replace for read-modify-write stores.
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [15:0] i_word,
   input  logic        i_lane,
   input  logic        i_sext,
   input  logic [7:0]  i_byte,
   output logic [15:0] o_load,
   output logic [15:0] o_merge
);

   logic [7:0] w_sel;

   assign w_sel   = (i_lane == LANE_LO) ? i_word[7:0] : i_word[15:8];
   assign o_load  = {{8{i_sext & w_sel[7]}}, w_sel};
   assign o_merge = (i_lane == LANE_HI) ? {i_byte, i_word[7:0]} : {i_word[15:8], i_byte};

endmodule

// File: rtl/dcache_lsu.sv
// Load/store unit for the 16-bit data cache; one request in flight, response held until i_resp_ready.
// Latency load 3 / word store 2 / byte store 4 / error 1; byte access built only with LSU_BYTE_ACCESS_EN.
module dcache_lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_WORDS = LSU_ADDR_WORDS
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic        i_req_byte,
   input  logic        i_req_sext,
   input  logic [15:0] i_req_addr,
   input  logic [15:0] i_req_wdata,
   output logic        o_resp_valid,
   input  logic        i_resp_ready,
   output logic [15:0] o_resp_rdata,
   output logic        o_resp_err,
   output logic        o_cache_r_en,
   output logic        o_cache_w_en,
   output logic [15:0] o_cache_addr,
   output logic [15:0] o_cache_w_data,
   input  logic [15:0] i_cache_r_data
);

   localparam logic [15:0] L_IDX_LIMIT = 16'(ADDR_WORDS);

   state_t      r_state;
   state_t      w_next;
   logic [14:0] r_idx;
   logic [15:0] r_wdat;
   logic [15:0] r_rdata;
   logic        r_err;

   logic        w_accept;
   logic        w_misal;
   logic        w_err;
   logic        w_byte;
   logic [14:0] w_idx;
   logic [15:0] w_load_fmt;

   assign w_accept = i_req_valid && o_req_ready;
   assign w_idx    = i_req_addr[15:1];

`ifdef LSU_BYTE_ACCESS_EN
   logic        r_byte;
   logic        r_lane;
   logic        r_sext;
   logic [15:0] w_lane_load;
   logic [15:0] w_lane_merge;

   assign w_byte  = i_req_byte;
   assign w_misal = !i_req_byte && i_req_addr[0];

   lsu_byte_lane u_byte_lane (
      .i_word  (i_cache_r_data),
      .i_lane  (r_lane),
      .i_sext  (r_sext),
      .i_byte  (r_wdat[7:0]),
      .o_load  (w_lane_load),
      .o_merge (w_lane_merge)
   );

   assign w_load_fmt = r_byte ? w_lane_load : i_cache_r_data;
`else
   logic w_unused;

   assign w_unused   = ^{i_req_byte, i_req_sext};
   assign w_byte     = 1'b0;
   assign w_misal    = i_req_addr[0];
   assign w_load_fmt = i_cache_r_data;
`endif

   assign w_err = w_misal || ({1'b0, w_idx} >= L_IDX_LIMIT);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_err)          w_next = S_RESP;
               else if (!i_req_we) w_next = S_LD_RD;
               else if (w_byte)    w_next = S_RMW_RD;
               else                w_next = S_ST_WR;
            end
         end
         S_LD_RD:   w_next = S_LD_CAP;
         S_LD_CAP:  w_next = S_RESP;
         S_ST_WR:   w_next = S_RESP;
`ifdef LSU_BYTE_ACCESS_EN
         S_RMW_RD:  w_next = S_RMW_MRG;
         S_RMW_MRG: w_next = S_ST_WR;
`endif
         S_RESP:    if (i_resp_ready) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Request latch; RMW_MRG overwrites the store data with the merged word.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_idx   <= '0;
         r_wdat  <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
`ifdef LSU_BYTE_ACCESS_EN
         r_byte  <= 1'b0;
         r_lane  <= 1'b0;
         r_sext  <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_idx   <= w_idx;
            r_wdat  <= i_req_wdata;
            r_rdata <= '0;
            r_err   <= w_err;
`ifdef LSU_BYTE_ACCESS_EN
            r_byte  <= i_req_byte;
            r_lane  <= i_req_addr[0];
            r_sext  <= i_req_sext;
`endif
         end
         if (r_state == S_LD_CAP) r_rdata <= w_load_fmt;
`ifdef LSU_BYTE_ACCESS_EN
         if (r_state == S_RMW_MRG) r_wdat <= w_lane_merge;
`endif
      end
   end

   always_comb begin
      o_req_ready    = (r_state == S_IDLE) && !i_reset;
      o_resp_valid   = (r_state == S_RESP);
      o_cache_r_en   = (r_state == S_LD_RD) || (r_state == S_RMW_RD);
      o_cache_w_en   = (r_state == S_ST_WR);
      o_cache_addr   = (r_state == S_IDLE) ? 16'h0000 : {1'b0, r_idx};
      o_cache_w_data = r_wdat;
      o_resp_rdata   = r_rdata;
      o_resp_err     = r_err;
   end

endmodule

// File: tb/tb_dcache_lsu.sv
// Directed bench for dcache_lsu with a synchronous 256-word cache model preloaded mem[i]=i.
// Byte-access scenarios follow LSU_BYTE_ACCESS_EN; the default build checks that byte flags are ignored.
module tb_dcache_lsu;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic        req_byte = 1'b0;
   logic        req_sext = 1'b0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [15:0] resp_rdata;
   logic        resp_err;
   logic        cache_r_en;
   logic        cache_w_en;
   logic [15:0] cache_addr;
   logic [15:0] cache_w_data;
   logic [15:0] cache_r_data = '0;

   logic [15:0] mem [0:255];
   logic        mem_loaded = 1'b0;
   int          r_pulses = 0;
   int          w_pulses = 0;
   logic [15:0] last_w_addr = '0;
   logic        both_hi = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dcache_lsu dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_req_valid    (req_valid),
      .o_req_ready    (req_ready),
      .i_req_we       (req_we),
      .i_req_byte     (req_byte),
      .i_req_sext     (req_sext),
      .i_req_addr     (req_addr),
      .i_req_wdata    (req_wdata),
      .o_resp_valid   (resp_valid),
      .i_resp_ready   (resp_ready),
      .o_resp_rdata   (resp_rdata),
      .o_resp_err     (resp_err),
      .o_cache_r_en   (cache_r_en),
      .o_cache_w_en   (cache_w_en),
      .o_cache_addr   (cache_addr),
      .o_cache_w_data (cache_w_data),
      .i_cache_r_data (cache_r_data)
   );

   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'(i);
         mem_loaded <= 1'b1;
      end else begin
         if (cache_r_en) begin
            cache_r_data <= mem[cache_addr[7:0]];
            r_pulses     <= r_pulses + 1;
         end
         if (cache_w_en) begin
            mem[cache_addr[7:0]] <= cache_w_data;
            w_pulses             <= w_pulses + 1;
            last_w_addr          <= cache_addr;
         end
         if (cache_r_en && cache_w_en) both_hi <= 1'b1;
      end
   end

   // Issues one request from IDLE, returns latency (0 on timeout) and the response, then completes the handshake.
   task automatic do_req(input logic we, input logic byt, input logic sx, input logic [15:0] addr,
                         input logic [15:0] wd, output int lat, output logic [15:0] rd, output logic er);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_byte = byt; req_sext = sx; req_addr = addr; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      for (int i = 1; i <= LAT_BSTORE + 16; i++) begin
         @(negedge clk);
         if (resp_valid) begin lat = i; break; end
      end
      rd = resp_rdata;
      er = resp_err;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
      total++; if ({cache_r_en, cache_w_en, resp_err} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {cache_r_en, cache_w_en, resp_err}); end
      total++; if ({cache_addr, cache_w_data, resp_rdata} !== 48'h0) begin bad++; $display("FAIL rst_buses got=%h exp=0", {cache_addr, cache_w_data, resp_rdata}); end
      rst = 1'b0;
      @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL idle_req_ready got=%b exp=1", req_ready); end
   endtask

   task automatic test_word_load();
      int lat; logic [15:0] rd; logic er;
      do_req(1'b0, 1'b0, 1'b0, 16'h0014, 16'h0000, lat, rd, er);
      total++; if (lat !== 3) begin bad++; $display("FAIL wld_lat got=%0d exp=3", lat); end
      total++; if (rd !== 16'h000A) begin bad++; $display("FAIL wld_data got=%h exp=000a", rd); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL wld_err got=%b exp=0", er); end
   endtask

   task automatic test_word_store();
      int lat; int w0; logic [15:0] rd; logic er;
      w0 = w_pulses;
      do_req(1'b1, 1'b0, 1'b0, 16'h0020, 16'hBEEF, lat, rd, er);
      total++; if (lat !== 2) begin bad++; $display("FAIL wst_lat got=%0d exp=2", lat); end
      total++; if ({er, rd} !== 17'h0) begin bad++; $display("FAIL wst_resp got=%h exp=0", {er, rd}); end
      total++; if (w_pulses - w0 !== 1) begin bad++; $display("FAIL wst_pulses got=%0d exp=1", w_pulses - w0); end
      total++; if (last_w_addr !== 16'h0010) begin bad++; $display("FAIL wst_index got=%h exp=0010", last_w_addr); end
      do_req(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, lat, rd, er);
      total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL wst_readback got=%h exp=beef", rd); end
   endtask

   task automatic test_byte_access();
      int lat; int w0; logic [15:0] rd; logic er;
      do_req(1'b1, 1'b0, 1'b0, 16'h0020, 16'h1234, lat, rd, er);
`ifdef LSU_BYTE_ACCESS_EN
      do_req(1'b1, 1'b1, 1'b0, 16'h0021, 16'h77A5, lat, rd, er);
      total++; if (lat !== 4) begin bad++; $display("FAIL bst_lat got=%0d exp=4", lat); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL bst_err got=%b exp=0", er); end
      total++; if (mem[16'h10] !== 16'hA534) begin bad++; $display("FAIL bst_hi_merge got=%h exp=a534", mem[16'h10]); end
      do_req(1'b0, 1'b1, 1'b1, 16'h0021, 16'h0000, lat, rd, er);
      total++; if (rd !== 16'hFFA5) begin bad++; $display("FAIL bld_sext got=%h exp=ffa5", rd); end
      total++; if (lat !== 3) begin bad++; $display("FAIL bld_lat got=%0d exp=3", lat); end
      do_req(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000, lat, rd, er);
      total++; if (rd !== 16'h00A5) begin bad++; $display("FAIL bld_zext got=%h exp=00a5", rd); end
      do_req(1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, lat, rd, er);
      total++; if (rd !== 16'h0034) begin bad++; $display("FAIL bld_lo_sext got=%h exp=0034", rd); end
      do_req(1'b1, 1'b1, 1'b0, 16'h0020, 16'hFF5A, lat, rd, er);
      total++; if (mem[16'h10] !== 16'hA55A) begin bad++; $display("FAIL bst_lo_merge got=%h exp=a55a", mem[16'h10]); end
`else
      w0 = w_pulses;
      do_req(1'b1, 1'b1, 1'b0, 16'h0021, 16'h77A5, lat, rd, er);
      total++; if ({er, lat} !== {1'b1, 32'd1}) begin bad++; $display("FAIL nobyte_st_err got=%b/%0d exp=1/1", er, lat); end
      total++; if (w_pulses !== w0) begin bad++; $display("FAIL nobyte_st_write got=%0d exp=%0d", w_pulses, w0); end
      total++; if (mem[16'h10] !== 16'h1234) begin bad++; $display("FAIL nobyte_mem got=%h exp=1234", mem[16'h10]); end
      do_req(1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, lat, rd, er);
      total++; if ({rd, lat} !== {16'h1234, 32'd3}) begin bad++; $display("FAIL nobyte_ld got=%h/%0d exp=1234/3", rd, lat); end
`endif
   endtask

   task automatic test_errors();
      int lat; int r0; int w0; logic [15:0] rd; logic er;
      r0 = r_pulses; w0 = w_pulses;
      do_req(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, lat, rd, er);
      total++; if ({er, lat} !== {1'b1, 32'd1}) begin bad++; $display("FAIL err_misal got=%b/%0d exp=1/1", er, lat); end
      total++; if (rd !== 16'h0000) begin bad++; $display("FAIL err_rdata got=%h exp=0000", rd); end
      do_req(1'b0, 1'b0, 1'b0, 16'h0200, 16'h0000, lat, rd, er);
      total++; if ({er, lat} !== {1'b1, 32'd1}) begin bad++; $display("FAIL err_range got=%b/%0d exp=1/1", er, lat); end
      do_req(1'b1, 1'b0, 1'b0, 16'h0200, 16'h5555, lat, rd, er);
      total++; if (er !== 1'b1) begin bad++; $display("FAIL err_range_st got=%b exp=1", er); end
      total++; if (r_pulses !== r0 || w_pulses !== w0) begin bad++; $display("FAIL err_cache_access got=r%0d/w%0d exp=r%0d/w%0d", r_pulses, w_pulses, r0, w0); end
      do_req(1'b0, 1'b0, 1'b0, 16'h01FE, 16'h0000, lat, rd, er);
      total++; if ({er, rd} !== {1'b0, 16'h00FF}) begin bad++; $display("FAIL last_word got=%b/%h exp=0/00ff", er, rd); end
   endtask

   task automatic test_backpressure();
      int n;
      resp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 16'h0014;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (resp_valid) begin n = i; break; end
      end
      total++; if (n !== 3) begin bad++; $display("FAIL bp_lat got=%0d exp=3", n); end
      for (int c = 0; c < 5; c++) begin
         total++; if ({resp_valid, resp_rdata, req_ready} !== {1'b1, 16'h000A, 1'b0}) begin bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%b exp=1/000a/0", c, resp_valid, resp_rdata, req_ready); end
         @(negedge clk);
      end
      req_valid = 1'b1; req_addr = 16'h0016; resp_ready = 1'b1;
      @(negedge clk);
      total++; if ({resp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL no_b2b got=%b exp=01", {resp_valid, req_ready}); end
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (resp_valid) begin n = i; break; end
      end
      total++; if ({n, resp_rdata} !== {32'd3, 16'h000B}) begin bad++; $display("FAIL after_bp got=%0d/%h exp=3/000b", n, resp_rdata); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_midflight();
      int lat; int w0; logic [15:0] rd; logic er;
      do_req(1'b1, 1'b0, 1'b0, 16'h0060, 16'h1234, lat, rd, er);
      w0 = w_pulses;
      @(negedge clk);
`ifdef LSU_BYTE_ACCESS_EN
      req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b1; req_sext = 1'b0; req_addr = 16'h0061; req_wdata = 16'h00A5;
`else
      req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_sext = 1'b0; req_addr = 16'h0060; req_wdata = 16'h00A5;
`endif
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      total++; if ({cache_r_en, cache_addr} !== {1'b1, 16'h0030}) begin bad++; $display("FAIL mid_read got=%b/%h exp=1/0030", cache_r_en, cache_addr); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++; if ({req_ready, resp_valid, cache_r_en, cache_w_en, resp_err} !== 5'b0) begin bad++; $display("FAIL mid_rst_flags got=%b exp=00000", {req_ready, resp_valid, cache_r_en, cache_w_en, resp_err}); end
      total++; if ({cache_addr, cache_w_data, resp_rdata} !== 48'h0) begin bad++; $display("FAIL mid_rst_buses got=%h exp=0", {cache_addr, cache_w_data, resp_rdata}); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_idle got=%b exp=1", req_ready); end
      total++; if ({mem[16'h30], w_pulses - w0} !== {16'h1234, 32'd0}) begin bad++; $display("FAIL mid_mem got=%h/%0d exp=1234/0", mem[16'h30], w_pulses - w0); end
      do_req(1'b0, 1'b0, 1'b0, 16'h0060, 16'h0000, lat, rd, er);
      total++; if ({lat, rd, er} !== {32'd3, 16'h1234, 1'b0}) begin bad++; $display("FAIL mid_next got=%0d/%h/%b exp=3/1234/0", lat, rd, er); end
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_word_store();
      test_byte_access();
      test_errors();
      test_backpressure();
      test_reset_midflight();
      total++; if (both_hi !== 1'b0) begin bad++; $display("FAIL rd_wr_overlap got=%b exp=0", both_hi); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
